regfile_wb_arbiter: RTL and testbench

Writeback-side driver for the register file write port. It merges two result sources into the single write port (we/rd/wd): the ALU pipe (fixed slot, stallable) and the load unit (valid/ready, buffered in an LQ_DEPTH-entry queue). It arbitrates with a starvation guard, drops writes to x0, and exports a pending-write mask so decode can detect hazards against in-flight loads.

---
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : ALU/load result sources and register-file write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int LQ_DEPTH = 4
);
    logic                        alu_valid;
    logic [4:0]                  alu_rd;
    logic [31:0]                 alu_wd;
    logic                        alu_stall;
    logic                        ld_valid;
    logic [4:0]                  ld_rd;
    logic [31:0]                 ld_wd;
    logic                        ld_ready;
    logic                        we;
    logic [4:0]                  rd;
    logic [31:0]                 wd;
    logic [31:0]                 pending;
    logic [$clog2(LQ_DEPTH):0]   lq_count;

    modport master (
        output alu_valid, alu_rd, alu_wd, ld_valid, ld_rd, ld_wd,
        input  alu_stall, ld_ready, we, rd, wd, pending, lq_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd, ld_valid, ld_rd, ld_wd,
        output alu_stall, ld_ready, we, rd, wd, pending, lq_count
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Merges ALU and queued load results onto the register-file
//               write port with a starvation guard and pending-load mask.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int C_PTR_W = $clog2(LQ_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0] C_FULL    = C_CNT_W'(LQ_DEPTH);
    localparam logic [C_STV_W-1:0] C_STV_MAX = C_STV_W'(STARVE_LIMIT);

    logic [4:0]          lq_rd_q [LQ_DEPTH];
    logic [31:0]         lq_wd_q [LQ_DEPTH];
    logic [C_PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [C_CNT_W-1:0]  count_q, count_d;
    logic [C_STV_W-1:0]  starve_q, starve_d;
    logic                we_q, we_d, from_lq_q, from_lq_d;
    logic [4:0]          rd_q, rd_d;
    logic [31:0]         wd_q, wd_d;

    logic                w_ld_ready, w_enq, w_force, w_grant_lq, w_grant_alu;
    logic [C_PTR_W-1:0]  w_idx;
    logic [31:0]         w_pending;

    assign w_ld_ready  = !rst && (count_q != C_FULL);
    // Loads to x0 complete the handshake but never occupy a slot.
    assign w_enq       = bus.ld_valid && w_ld_ready && (bus.ld_rd != 5'd0);
    assign w_force     = (starve_q >= C_STV_MAX) && (count_q != '0);
    assign w_grant_lq  = w_force || (!bus.alu_valid && (count_q != '0));
    assign w_grant_alu = bus.alu_valid && !w_force;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        starve_d  = starve_q;
        we_d      = 1'b0;
        rd_d      = rd_q;
        wd_d      = wd_q;
        from_lq_d = from_lq_q;

        if (w_grant_lq) begin
            we_d      = (lq_rd_q[head_q] != 5'd0);
            rd_d      = lq_rd_q[head_q];
            wd_d      = lq_wd_q[head_q];
            from_lq_d = 1'b1;
            head_d    = head_q + C_PTR_W'(1);
        end else if (w_grant_alu) begin
            we_d      = (bus.alu_rd != 5'd0);
            rd_d      = bus.alu_rd;
            wd_d      = bus.alu_wd;
            from_lq_d = 1'b0;
        end

        if (w_grant_lq || (count_q == '0)) begin
            starve_d = '0;
        end else if (w_grant_alu && (starve_q != C_STV_MAX)) begin
            starve_d = starve_q + C_STV_W'(1);
        end

        if (w_enq) begin
            tail_d = tail_q + C_PTR_W'(1);
        end

        case ({w_enq, w_grant_lq})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            we_q      <= 1'b0;
            rd_q      <= 5'd0;
            wd_q      <= 32'd0;
            from_lq_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            wd_q      <= wd_d;
            from_lq_q <= from_lq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            lq_rd_q[tail_q] <= bus.ld_rd;
            lq_wd_q[tail_q] <= bus.ld_wd;
        end
    end

    // Only slots between head and head+count hold live loads.
    always_comb begin
        w_pending = 32'd0;
        w_idx     = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            w_idx = head_q + C_PTR_W'(i);
            if (C_CNT_W'(i) < count_q) begin
                w_pending[lq_rd_q[w_idx]] = 1'b1;
            end
        end
        if (we_q && from_lq_q) begin
            w_pending[rd_q] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    assign bus.alu_stall = w_force && bus.alu_valid;
    assign bus.ld_ready  = w_ld_ready;
    assign bus.we        = we_q;
    assign bus.rd        = rd_q;
    assign bus.wd        = wd_q;
    assign bus.pending   = w_pending;
    assign bus.lq_count  = count_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed and randomized checks of the writeback arbiter
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter_if #(.LQ_DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(.LQ_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] rd; logic [31:0] wd; } ld_t;
    ld_t         mq[$];
    int          m_starve = 0;
    bit          m_we = 0;
    bit          m_src = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_wd = 0;

    function automatic bit m_ready();
        return !rst && (mq.size() != DEPTH);
    endfunction

    function automatic bit m_force();
        return (m_starve >= LIMIT) && (mq.size() != 0);
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = 32'd0;
        foreach (mq[i]) p[mq[i].rd] = 1'b1;
        if (m_we && m_src) p[m_rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Advance the model by one cycle from the current inputs, then cross the edge.
    task automatic tick(output bit alu_taken, output bit ld_acc);
        bit  frc;
        ld_t h;
        frc       = m_force();
        ld_acc    = bus.ld_valid && m_ready();
        alu_taken = bus.alu_valid && !frc;
        if (rst) begin
            mq.delete();
            m_starve = 0; m_we = 0; m_src = 0; m_rd = 0; m_wd = 0;
        end else begin
            if (frc || (!bus.alu_valid && mq.size() != 0)) begin
                h = mq.pop_front();
                m_we = (h.rd != 0); m_rd = h.rd; m_wd = h.wd; m_src = 1; m_starve = 0;
            end else if (bus.alu_valid) begin
                m_we = (bus.alu_rd != 0); m_rd = bus.alu_rd; m_wd = bus.alu_wd; m_src = 0;
                if (mq.size() == 0) m_starve = 0;
                else m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            end else begin
                m_we = 0; m_starve = 0;
            end
            if (ld_acc && bus.ld_rd != 0) mq.push_back({bus.ld_rd, bus.ld_wd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit t, a;
        for (int c = 0; c < 3; c++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'($urandom_range(1, 31)); bus.alu_wd = $urandom;
            bus.ld_valid  = 1'b1; bus.ld_rd  = 5'($urandom_range(1, 31)); bus.ld_wd  = $urandom;
            tick(t, a);
            checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus.we); end
            checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL rst_pending got %h exp 0", bus.pending); end
            checks++; if (bus.lq_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.lq_count); end
            checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.ld_ready); end
            checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.alu_stall); end
        end
        rst = 1'b0; bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", bus.ld_ready); end
        tick(t, a);
    endtask

    task automatic test_alu_only();
        bit t, a;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_wd = 32'hDEADBEEF;
        #1;
        checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", bus.alu_stall); end
        tick(t, a);
        bus.alu_valid = 1'b0;
        checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL alu_we got %b exp 1", bus.we); end
        checks++; if (bus.rd !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d exp 5", bus.rd); end
        checks++; if (bus.wd !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wd got %h exp deadbeef", bus.wd); end
        tick(t, a);
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL alu_we2 got %b exp 0", bus.we); end
    endtask

    task automatic test_load_x0();
        bit t, a;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_wd = 32'h11;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready got %b exp 1", bus.ld_ready); end
        tick(t, a);
        bus.ld_rd = 5'd0; bus.ld_wd = 32'h22;
        #1;
        checks++; if (bus.lq_count !== 3'd1) begin errors++; $display("FAIL ld_count1 got %0d exp 1", bus.lq_count); end
        checks++; if (bus.pending !== 32'h80) begin errors++; $display("FAIL ld_pend1 got %h exp 80", bus.pending); end
        tick(t, a);
        bus.ld_valid = 1'b0;
        checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd7 || bus.wd !== 32'h11) begin
            errors++; $display("FAIL ld_write got we=%b rd=%0d wd=%h exp we=1 rd=7 wd=11", bus.we, bus.rd, bus.wd); end
        checks++; if (bus.lq_count !== 3'd0) begin errors++; $display("FAIL ld_x0_count got %0d exp 0", bus.lq_count); end
        checks++; if (bus.pending !== 32'h80) begin errors++; $display("FAIL ld_pend2 got %h exp 80", bus.pending); end
        for (int c = 0; c < 3; c++) begin
            tick(t, a);
            checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL ld_x0_we got %b exp 0", bus.we); end
        end
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL ld_pend3 got %h exp 0", bus.pending); end
    endtask

    task automatic test_full_queue();
        bit t, a, saw_block;
        int acc_n, n;
        logic [4:0] got[$];
        acc_n = 0; n = 0; saw_block = 0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_wd = $urandom;
        for (int c = 0; c < 20 && acc_n < 5; c++) begin
            bus.ld_valid = 1'b1; bus.ld_rd = 5'(acc_n + 1); bus.ld_wd = 32'h100 + acc_n;
            #1;
            checks++; if (bus.lq_count > 3'd4) begin errors++; $display("FAIL fq_count got %0d exp <=4", bus.lq_count); end
            checks++; if (bus.ld_ready !== m_ready()) begin errors++; $display("FAIL fq_ready got %b exp %b", bus.ld_ready, m_ready()); end
            if (acc_n == 4 && !bus.ld_ready) saw_block = 1;
            tick(t, a);
            if (a) acc_n++;
            if (t) begin n++; bus.alu_rd = 5'(20 + n % 10); bus.alu_wd = $urandom; end
            if (bus.we && bus.rd >= 5'd1 && bus.rd <= 5'd5) got.push_back(bus.rd);
        end
        bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
        checks++; if (acc_n != 5) begin errors++; $display("FAIL fq_accepted got %0d exp 5", acc_n); end
        checks++; if (!saw_block) begin errors++; $display("FAIL fq_block got 0 exp 1"); end
        for (int c = 0; c < 8; c++) begin
            tick(t, a);
            if (bus.we && bus.rd >= 5'd1 && bus.rd <= 5'd5) got.push_back(bus.rd);
        end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL fq_nwrites got %0d exp 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== 5'(i + 1)) begin
                errors++; $display("FAIL fq_order idx %0d got %0d exp %0d", i, (got.size() > i) ? got[i] : 5'd0, i + 1); end
        end
    endtask

    task automatic test_starvation();
        bit t, a;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_wd = 32'hA000_0000;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd9;  bus.ld_wd  = 32'h0000_0909;
        #1;
        checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL stv_c0 got %b exp 0", bus.alu_stall); end
        tick(t, a);
        bus.ld_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.alu_rd = 5'(10 + k); bus.alu_wd = 32'hA000_0000 + k;
            #1;
            checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL stv_win%0d got %b exp 0", k, bus.alu_stall); end
            checks++; if (bus.pending !== 32'h200) begin errors++; $display("FAIL stv_pend%0d got %h exp 200", k, bus.pending); end
            tick(t, a);
            checks++; if (bus.we !== 1'b1 || bus.rd !== 5'(10 + k)) begin
                errors++; $display("FAIL stv_alu%0d got we=%b rd=%0d exp we=1 rd=%0d", k, bus.we, bus.rd, 10 + k); end
        end
        bus.alu_rd = 5'd14; bus.alu_wd = 32'hA000_0004;
        #1;
        checks++; if (bus.alu_stall !== 1'b1) begin errors++; $display("FAIL stv_force got %b exp 1", bus.alu_stall); end
        tick(t, a);
        checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd9 || bus.wd !== 32'h909) begin
            errors++; $display("FAIL stv_load got we=%b rd=%0d wd=%h exp we=1 rd=9 wd=909", bus.we, bus.rd, bus.wd); end
        checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL stv_after got %b exp 0", bus.alu_stall); end
        tick(t, a);
        checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd14 || bus.wd !== 32'hA000_0004) begin
            errors++; $display("FAIL stv_held got we=%b rd=%0d wd=%h exp we=1 rd=14 wd=a0000004", bus.we, bus.rd, bus.wd); end
        bus.alu_valid = 1'b0;
        tick(t, a);
    endtask

    task automatic test_back_to_back();
        bit t, a;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_wd = 32'h1;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd12; bus.ld_wd = 32'hA;
        tick(t, a);
        bus.alu_rd = 5'd2; bus.alu_wd = 32'h2; bus.ld_rd = 5'd13; bus.ld_wd = 32'hB;
        tick(t, a);
        bus.alu_valid = 1'b0; bus.ld_rd = 5'd14; bus.ld_wd = 32'hC;
        #1;
        checks++; if (bus.lq_count !== 3'd2) begin errors++; $display("FAIL sim_pre got %0d exp 2", bus.lq_count); end
        tick(t, a);
        bus.ld_valid = 1'b0;
        checks++; if (bus.lq_count !== 3'd2) begin errors++; $display("FAIL sim_post got %0d exp 2", bus.lq_count); end
        checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd12 || bus.wd !== 32'hA) begin
            errors++; $display("FAIL sim_w0 got rd=%0d wd=%h exp rd=12 wd=a", bus.rd, bus.wd); end
        tick(t, a);
        checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd13 || bus.wd !== 32'hB) begin
            errors++; $display("FAIL sim_w1 got rd=%0d wd=%h exp rd=13 wd=b", bus.rd, bus.wd); end
        tick(t, a);
        checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd14 || bus.wd !== 32'hC) begin
            errors++; $display("FAIL sim_w2 got rd=%0d wd=%h exp rd=14 wd=c", bus.rd, bus.wd); end
        checks++; if (bus.lq_count !== 3'd0) begin errors++; $display("FAIL sim_empty got %0d exp 0", bus.lq_count); end
    endtask

    task automatic test_random();
        bit t, a, alu_hold, ld_hold;
        alu_hold = 0; ld_hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (!alu_hold) begin
                bus.alu_valid = ($urandom_range(0, 3) != 0);
                bus.alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.alu_wd = $urandom;
            end
            if (!ld_hold) begin
                bus.ld_valid = ($urandom_range(0, 1) != 0);
                bus.ld_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.ld_wd = $urandom;
            end
            rst = ($urandom_range(0, 79) == 0);
            #1;
            checks++; if (bus.ld_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, bus.ld_ready, m_ready()); end
            checks++; if (bus.alu_stall !== (bus.alu_valid && m_force())) begin
                errors++; $display("FAIL rnd_stall c%0d got %b exp %b", c, bus.alu_stall, bus.alu_valid && m_force()); end
            checks++; if (bus.lq_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, bus.lq_count, mq.size()); end
            checks++; if (bus.pending !== m_pending()) begin errors++; $display("FAIL rnd_pend c%0d got %h exp %h", c, bus.pending, m_pending()); end
            tick(t, a);
            alu_hold = bus.alu_valid && !t && !rst;
            ld_hold  = bus.ld_valid && !a && !rst;
            checks++; if (bus.we !== m_we || bus.rd !== m_rd || bus.wd !== m_wd) begin
                errors++; $display("FAIL rnd_out c%0d got we=%b rd=%0d wd=%h exp we=%b rd=%0d wd=%h", c, bus.we, bus.rd, bus.wd, m_we, m_rd, m_wd); end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_wd = 32'd0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = 5'd0; bus.ld_wd  = 32'd0;
        test_reset();
        test_alu_only();
        test_load_x0();
        test_full_queue();
        test_starvation();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
